operand_fetch: RTL

- Register-fetch/forward (RF/FWD) stage that feeds both execution pipes.
- Holds the 128x128 register file and accepts the writeback ports of the even and odd pipes.
- Resolves each source operand from the forwarding staging registers of both pipes, else from writeback, else from the file.
- A per-register latency scoreboard stalls decode on RAW hazards; issued operands are registered for the pipes.

---
 rtl/ofetch_pkg.sv | 36 +++
 rtl/operand_fetch_fwd_select.sv | 33 +++
 rtl/operand_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ofetch_pkg.sv
// Shared sizes, staging-bus types and operand indices for the operand fetch stage.
package ofetch_pkg;

    localparam int REGS     = 128;
    localparam int REG_W    = 128;
    localparam int ADDR_W   = 7;
    localparam int FW_DEPTH = 7;
    localparam int LAT_W    = 4;
    localparam int NUM_OPS  = 6;

    typedef logic [FW_DEPTH-1:0][REG_W-1:0]  fw_data_t;
    typedef logic [FW_DEPTH-1:0][ADDR_W-1:0] fw_addr_t;
    typedef logic [FW_DEPTH-1:0]             fw_write_t;

    typedef struct packed {
        fw_data_t  data;
        fw_addr_t  addr;
        fw_write_t write;
    } fw_bus_t;

    typedef enum logic [2:0] {
        RA_E   = 3'd0,
        RB_E   = 3'd1,
        RC_E   = 3'd2,
        RA_O   = 3'd3,
        RB_O   = 3'd4,
        RTST_O = 3'd5
    } op_idx_t;

    function automatic logic addr_hit(input logic wr,
                                      input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
        return wr && (a == b);
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_select.sv
// One-operand priority mux: staging (youngest first, odd before even), then wb_o, wb_e, file.
module fwd_select
    import ofetch_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  fw_bus_t           fw_e,
    input  fw_bus_t           fw_o,
    input  logic [REG_W-1:0]  wb_e_data,
    input  logic [ADDR_W-1:0] wb_e_addr,
    input  logic              wb_e_write,
    input  logic [REG_W-1:0]  wb_o_data,
    input  logic [ADDR_W-1:0] wb_o_addr,
    input  logic              wb_o_write,
    input  logic [REG_W-1:0]  rf_data,
    output logic [REG_W-1:0]  data
);

    logic [REG_W-1:0] pick_s;

    // Weakest source first; each stronger source overrides it on an address hit.
    always_comb begin
        pick_s = rf_data;
        pick_s = addr_hit(wb_e_write, wb_e_addr, addr) ? wb_e_data : pick_s;
        pick_s = addr_hit(wb_o_write, wb_o_addr, addr) ? wb_o_data : pick_s;
        for (int s = FW_DEPTH - 1; s >= 0; s--) begin
            pick_s = addr_hit(fw_e.write[s], fw_e.addr[s], addr) ? fw_e.data[s] : pick_s;
            pick_s = addr_hit(fw_o.write[s], fw_o.addr[s], addr) ? fw_o.data[s] : pick_s;
        end
        data = en ? pick_s : {REG_W{1'b0}};
    end

endmodule

// File: rtl/operand_fetch.sv
// RF/FWD stage: register file, latency scoreboard, operand resolution and issue registers.
module operand_fetch
    import ofetch_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              dec_valid,
    output logic                              dec_ready,
    input  logic [NUM_OPS-1:0][ADDR_W-1:0]    src_addr,
    input  logic [NUM_OPS-1:0]                src_en,
    input  logic [ADDR_W-1:0]                 rt_e,
    input  logic [ADDR_W-1:0]                 rt_o,
    input  logic                              wr_e,
    input  logic                              wr_o,
    input  logic [LAT_W-1:0]                  lat_e,
    input  logic [LAT_W-1:0]                  lat_o,
    input  logic                              flush,
    input  logic [REG_W-1:0]                  wb_e_data,
    input  logic [ADDR_W-1:0]                 wb_e_addr,
    input  logic                              wb_e_write,
    input  logic [REG_W-1:0]                  wb_o_data,
    input  logic [ADDR_W-1:0]                 wb_o_addr,
    input  logic                              wb_o_write,
    input  logic [FW_DEPTH-1:0][REG_W-1:0]    fw_e_data,
    input  logic [FW_DEPTH-1:0][ADDR_W-1:0]   fw_e_addr,
    input  logic [FW_DEPTH-1:0]               fw_e_write,
    input  logic [FW_DEPTH-1:0][REG_W-1:0]    fw_o_data,
    input  logic [FW_DEPTH-1:0][ADDR_W-1:0]   fw_o_addr,
    input  logic [FW_DEPTH-1:0]               fw_o_write,
    output logic [NUM_OPS-1:0][REG_W-1:0]     op_val,
    output logic                              op_valid,
    output logic [31:0]                       stall_cycles
);

    logic [REG_W-1:0]              rf_r [REGS];
    logic [LAT_W-1:0]              sb_cnt_r [REGS];
    logic [NUM_OPS-1:0][REG_W-1:0] sel_data_s;
    logic                          hazard_s;
    logic                          fire_s;
    fw_bus_t                       fw_e_bus_s;
    fw_bus_t                       fw_o_bus_s;

    assign fw_e_bus_s.data  = fw_e_data;
    assign fw_e_bus_s.addr  = fw_e_addr;
    assign fw_e_bus_s.write = fw_e_write;
    assign fw_o_bus_s.data  = fw_o_data;
    assign fw_o_bus_s.addr  = fw_o_addr;
    assign fw_o_bus_s.write = fw_o_write;

    // RAW hazard: any enabled source still has results in flight.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            hazard_s = hazard_s | (src_en[i] & (sb_cnt_r[src_addr[i]] != {LAT_W{1'b0}}));
        end
    end

    assign dec_ready = ~hazard_s;
    assign fire_s    = dec_valid & ~hazard_s & ~flush;

    // Scoreboard counters: odd load beats even load beats decrement.
    always_ff @(posedge clk) begin
        for (int r = 0; r < REGS; r++) begin
            if (reset) begin
                sb_cnt_r[r] <= {LAT_W{1'b0}};
            end else if (fire_s && wr_o && (rt_o == ADDR_W'(r))) begin
                sb_cnt_r[r] <= lat_o;
            end else if (fire_s && wr_e && (rt_e == ADDR_W'(r))) begin
                sb_cnt_r[r] <= lat_e;
            end else if (sb_cnt_r[r] != {LAT_W{1'b0}}) begin
                sb_cnt_r[r] <= sb_cnt_r[r] - LAT_W'(1);
            end else begin
                sb_cnt_r[r] <= sb_cnt_r[r];
            end
        end
    end

    // Register file writes; the odd port is applied last so it wins on a shared address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGS; r++) begin
                rf_r[r] <= {REG_W{1'b0}};
            end
        end else begin
            if (wb_e_write) begin
                rf_r[wb_e_addr] <= wb_e_data;
            end
            if (wb_o_write) begin
                rf_r[wb_o_addr] <= wb_o_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_sel
        fwd_select u_sel (
            .en         (src_en[g]),
            .addr       (src_addr[g]),
            .fw_e       (fw_e_bus_s),
            .fw_o       (fw_o_bus_s),
            .wb_e_data  (wb_e_data),
            .wb_e_addr  (wb_e_addr),
            .wb_e_write (wb_e_write),
            .wb_o_data  (wb_o_data),
            .wb_o_addr  (wb_o_addr),
            .wb_o_write (wb_o_write),
            .rf_data    (rf_r[src_addr[g]]),
            .data       (sel_data_s[g])
        );
    end

    // Issue registers: values captured only on fire, valid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_val   <= {(NUM_OPS*REG_W){1'b0}};
            op_valid <= 1'b0;
        end else if (fire_s) begin
            op_val   <= sel_data_s;
            op_valid <= 1'b1;
        end else begin
            op_valid <= 1'b0;
        end
    end

    // Stall counter ignores cycles where the pair is being killed anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (dec_valid && hazard_s && !flush) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
